vls_unit: RTL and testbench

VLS_UNIT -- requirements
Module: vls_unit

---
 rtl/vls_unit_if.sv | 45 ++++
 rtl/vls_unit.sv | 194 +++++++++++++++++++
 tb/tb_vls_unit.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/vls_unit_if.sv
// Port bundle for the vector load/store unit: shared issue controls plus two
// independent lanes (_a/_b) of request and writeback signals.
interface vls_if #(
  parameter int ELEMS = 4
) ();
  logic                   valid;
  logic [6:0]             op;
  logic                   ready_in;
  logic                   vec_res;
  logic                   ready_out;

  logic [31:0]            imm_a,        imm_b;
  logic [31:0]            rs1_a,        rs1_b;
  logic [3:0]             vd_a,         vd_b;
  logic [3:0]             v2_a,         v2_b;
  logic                   row_col_a,    row_col_b;
  logic [4:0]             num_rows_a,   num_rows_b;
  logic [4:0]             num_cols_a,   num_cols_b;
  logic                   id_a,         id_b;
  logic [ELEMS-1:0][31:0] load_data_a,  load_data_b;

  logic                   req_a,        req_b;
  logic                   wen_a,        wen_b;
  logic [31:0]            addr_a,       addr_b;
  logic [3:0]             vs_a,         vs_b;
  logic                   row_col_o_a,  row_col_o_b;
  logic [4:0]             num_rows_o_a, num_rows_o_b;
  logic [4:0]             num_cols_o_a, num_cols_o_b;
  logic                   id_o_a,       id_o_b;
  logic                   wb_en_a,      wb_en_b;
  logic [3:0]             wb_vd_a,      wb_vd_b;
  logic [ELEMS-1:0][31:0] wb_data_a,    wb_data_b;

  modport dut (
    input  valid, op, ready_in, vec_res,
    input  imm_a, imm_b, rs1_a, rs1_b, vd_a, vd_b, v2_a, v2_b,
    input  row_col_a, row_col_b, num_rows_a, num_rows_b,
    input  num_cols_a, num_cols_b, id_a, id_b, load_data_a, load_data_b,
    output req_a, req_b, wen_a, wen_b, addr_a, addr_b, vs_a, vs_b,
    output row_col_o_a, row_col_o_b, num_rows_o_a, num_rows_o_b,
    output num_cols_o_a, num_cols_o_b, id_o_a, id_o_b,
    output wb_en_a, wb_en_b, wb_vd_a, wb_vd_b, wb_data_a, wb_data_b,
    output ready_out
  );
endinterface

// File: rtl/vls_unit.sv
// Two-lane vector load/store issue unit. Each lane registers its memory request
// and keeps a FIFO of pending load destinations that is drained by vec_res.
module vls_lane #(
  parameter int         ELEMS     = 4,
  parameter int         QDEPTH    = 4,
  parameter logic [6:0] OP_VLOAD  = 7'b0101000,
  parameter logic [6:0] OP_VSTORE = 7'b0100111
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid,
  input  logic [6:0]             op,
  input  logic                   ready_in,
  input  logic                   vec_res,
  input  logic [31:0]            imm,
  input  logic [31:0]            rs1,
  input  logic [3:0]             vd,
  input  logic [3:0]             v2,
  input  logic                   row_col,
  input  logic [4:0]             num_rows,
  input  logic [4:0]             num_cols,
  input  logic                   id,
  input  logic [ELEMS-1:0][31:0] load_data,
  output logic                   req,
  output logic                   wen,
  output logic [31:0]            addr,
  output logic [3:0]             vs,
  output logic                   row_col_o,
  output logic [4:0]             num_rows_o,
  output logic [4:0]             num_cols_o,
  output logic                   id_o,
  output logic                   wb_en,
  output logic [3:0]             wb_vd,
  output logic [ELEMS-1:0][31:0] wb_data,
  output logic                   full
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  logic [3:0]    fifo_q [QDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic is_store;
  logic is_load;
  logic issue;
  logic push;
  logic pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign is_store = (op == OP_VSTORE);
  assign is_load  = (op == OP_VLOAD);
  assign full     = (count == CW'(QDEPTH));
  // A load may only issue while its destination can be queued.
  assign issue    = valid && ready_in && (is_store || (is_load && !full));
  assign push     = issue && is_load;
  assign pop      = vec_res && (count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req        <= 1'b0;
      wen        <= 1'b0;
      addr       <= '0;
      vs         <= '0;
      row_col_o  <= 1'b0;
      num_rows_o <= '0;
      num_cols_o <= '0;
      id_o       <= 1'b0;
    end else begin
      req <= issue;
      if (issue) begin
        wen        <= is_store;
        addr       <= rs1 + imm;
        vs         <= v2;
        row_col_o  <= row_col;
        num_rows_o <= num_rows;
        num_cols_o <= num_cols;
        id_o       <= id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) fifo_q[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      wb_en   <= 1'b0;
      wb_vd   <= '0;
      wb_data <= '0;
    end else begin
      wb_en <= pop;
      if (push) begin
        fifo_q[wr_ptr] <= vd;
        wr_ptr         <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        wb_vd   <= fifo_q[rd_ptr];
        wb_data <= load_data;
        rd_ptr  <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module vls_unit #(
  parameter int         ELEMS     = 4,
  parameter int         QDEPTH    = 4,
  parameter logic [6:0] OP_VLOAD  = 7'b0101000,
  parameter logic [6:0] OP_VSTORE = 7'b0100111
) (
  input logic CLK,
  input logic nRST,
  vls_if.dut  vlsif
);
  logic full_a;
  logic full_b;

  assign vlsif.ready_out = vlsif.ready_in && !full_a && !full_b;

  vls_lane #(
    .ELEMS(ELEMS), .QDEPTH(QDEPTH), .OP_VLOAD(OP_VLOAD), .OP_VSTORE(OP_VSTORE)
  ) u_lane_a (
    .clk        (CLK),
    .rst_n      (nRST),
    .valid      (vlsif.valid),
    .op         (vlsif.op),
    .ready_in   (vlsif.ready_in),
    .vec_res    (vlsif.vec_res),
    .imm        (vlsif.imm_a),
    .rs1        (vlsif.rs1_a),
    .vd         (vlsif.vd_a),
    .v2         (vlsif.v2_a),
    .row_col    (vlsif.row_col_a),
    .num_rows   (vlsif.num_rows_a),
    .num_cols   (vlsif.num_cols_a),
    .id         (vlsif.id_a),
    .load_data  (vlsif.load_data_a),
    .req        (vlsif.req_a),
    .wen        (vlsif.wen_a),
    .addr       (vlsif.addr_a),
    .vs         (vlsif.vs_a),
    .row_col_o  (vlsif.row_col_o_a),
    .num_rows_o (vlsif.num_rows_o_a),
    .num_cols_o (vlsif.num_cols_o_a),
    .id_o       (vlsif.id_o_a),
    .wb_en      (vlsif.wb_en_a),
    .wb_vd      (vlsif.wb_vd_a),
    .wb_data    (vlsif.wb_data_a),
    .full       (full_a)
  );

  vls_lane #(
    .ELEMS(ELEMS), .QDEPTH(QDEPTH), .OP_VLOAD(OP_VLOAD), .OP_VSTORE(OP_VSTORE)
  ) u_lane_b (
    .clk        (CLK),
    .rst_n      (nRST),
    .valid      (vlsif.valid),
    .op         (vlsif.op),
    .ready_in   (vlsif.ready_in),
    .vec_res    (vlsif.vec_res),
    .imm        (vlsif.imm_b),
    .rs1        (vlsif.rs1_b),
    .vd         (vlsif.vd_b),
    .v2         (vlsif.v2_b),
    .row_col    (vlsif.row_col_b),
    .num_rows   (vlsif.num_rows_b),
    .num_cols   (vlsif.num_cols_b),
    .id         (vlsif.id_b),
    .load_data  (vlsif.load_data_b),
    .req        (vlsif.req_b),
    .wen        (vlsif.wen_b),
    .addr       (vlsif.addr_b),
    .vs         (vlsif.vs_b),
    .row_col_o  (vlsif.row_col_o_b),
    .num_rows_o (vlsif.num_rows_o_b),
    .num_cols_o (vlsif.num_cols_o_b),
    .id_o       (vlsif.id_o_b),
    .wb_en      (vlsif.wb_en_b),
    .wb_vd      (vlsif.wb_vd_b),
    .wb_data    (vlsif.wb_data_b),
    .full       (full_b)
  );
endmodule

// File: tb/tb_vls_unit.sv
// Bench for vls_unit: directed scenarios followed by random traffic, all checked
// against a per-lane reference model of issue and a shift-array load queue.
module tb_vls_unit;
  localparam int         QD = 4;
  localparam logic [6:0] LD = 7'b0101000;
  localparam logic [6:0] ST = 7'b0100111;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  vls_if #(.ELEMS(4)) vif ();

  vls_unit #(.ELEMS(4), .QDEPTH(QD), .OP_VLOAD(LD), .OP_VSTORE(ST)) dut (
    .CLK   (clk),
    .nRST  (rst_n),
    .vlsif (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state, index 0 = lane a, 1 = lane b
  logic [3:0]   fq [2][QD];
  int           cnt [2];
  logic         e_req [2], e_wen [2], e_rc [2], e_id [2], e_wben [2];
  logic [31:0]  e_addr [2];
  logic [3:0]   e_vs [2], e_wbvd [2];
  logic [4:0]   e_nr [2], e_nc [2];
  logic [127:0] e_wbdata [2];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int l = 0; l < 2; l++) begin
      cnt[l] = 0;
      for (int i = 0; i < QD; i++) fq[l][i] = '0;
      e_req[l] = 0; e_wen[l] = 0; e_rc[l] = 0; e_id[l] = 0; e_wben[l] = 0;
      e_addr[l] = '0; e_vs[l] = '0; e_wbvd[l] = '0;
      e_nr[l] = '0; e_nc[l] = '0; e_wbdata[l] = '0;
    end
  endfunction

  // One clock: inputs must already be driven.
  task automatic tick();
    logic [31:0]  rs1 [2], imm [2];
    logic [3:0]   vd [2], v2 [2];
    logic         rc [2], id [2];
    logic [4:0]   nr [2], nc [2];
    logic [127:0] ld [2];
    bit           iss, pop;
    logic         g_req [2], g_wen [2], g_rc [2], g_id [2], g_wben [2];
    logic [31:0]  g_addr [2];
    logic [3:0]   g_vs [2], g_wbvd [2];
    logic [4:0]   g_nr [2], g_nc [2];
    logic [127:0] g_wbdata [2];
    string        s;

    #1;
    rs1[0] = vif.rs1_a; rs1[1] = vif.rs1_b; imm[0] = vif.imm_a; imm[1] = vif.imm_b;
    vd[0] = vif.vd_a; vd[1] = vif.vd_b; v2[0] = vif.v2_a; v2[1] = vif.v2_b;
    rc[0] = vif.row_col_a; rc[1] = vif.row_col_b; id[0] = vif.id_a; id[1] = vif.id_b;
    nr[0] = vif.num_rows_a; nr[1] = vif.num_rows_b;
    nc[0] = vif.num_cols_a; nc[1] = vif.num_cols_b;
    ld[0] = vif.load_data_a; ld[1] = vif.load_data_b;

    chk("ready_out", vif.ready_out, vif.ready_in && cnt[0] < QD && cnt[1] < QD);

    for (int l = 0; l < 2; l++) begin
      iss = vif.valid && vif.ready_in &&
            (vif.op == ST || (vif.op == LD && cnt[l] < QD));
      pop = vif.vec_res && cnt[l] > 0;
      e_req[l] = iss;
      if (iss) begin
        e_wen[l] = (vif.op == ST); e_addr[l] = rs1[l] + imm[l]; e_vs[l] = v2[l];
        e_rc[l] = rc[l]; e_nr[l] = nr[l]; e_nc[l] = nc[l]; e_id[l] = id[l];
      end
      e_wben[l] = pop;
      if (pop) begin
        e_wbvd[l] = fq[l][0];
        e_wbdata[l] = ld[l];
        for (int i = 0; i < QD - 1; i++) fq[l][i] = fq[l][i+1];
        cnt[l]--;
      end
      if (iss && vif.op == LD) begin
        fq[l][cnt[l]] = vd[l];
        cnt[l]++;
      end
    end

    @(posedge clk);
    #1;
    g_req[0] = vif.req_a; g_req[1] = vif.req_b; g_wen[0] = vif.wen_a; g_wen[1] = vif.wen_b;
    g_addr[0] = vif.addr_a; g_addr[1] = vif.addr_b; g_vs[0] = vif.vs_a; g_vs[1] = vif.vs_b;
    g_rc[0] = vif.row_col_o_a; g_rc[1] = vif.row_col_o_b;
    g_nr[0] = vif.num_rows_o_a; g_nr[1] = vif.num_rows_o_b;
    g_nc[0] = vif.num_cols_o_a; g_nc[1] = vif.num_cols_o_b;
    g_id[0] = vif.id_o_a; g_id[1] = vif.id_o_b;
    g_wben[0] = vif.wb_en_a; g_wben[1] = vif.wb_en_b;
    g_wbvd[0] = vif.wb_vd_a; g_wbvd[1] = vif.wb_vd_b;
    g_wbdata[0] = vif.wb_data_a; g_wbdata[1] = vif.wb_data_b;
    for (int l = 0; l < 2; l++) begin
      s = (l == 0) ? "_a" : "_b";
      chk({"req", s}, g_req[l], e_req[l]);
      chk({"wen", s}, g_wen[l], e_wen[l]);
      chk({"addr", s}, g_addr[l], e_addr[l]);
      chk({"vs", s}, g_vs[l], e_vs[l]);
      chk({"row_col_o", s}, g_rc[l], e_rc[l]);
      chk({"num_rows_o", s}, g_nr[l], e_nr[l]);
      chk({"num_cols_o", s}, g_nc[l], e_nc[l]);
      chk({"id_o", s}, g_id[l], e_id[l]);
      chk({"wb_en", s}, g_wben[l], e_wben[l]);
      chk({"wb_vd", s}, g_wbvd[l], e_wbvd[l]);
      chk({"wb_data", s}, g_wbdata[l], e_wbdata[l]);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req_a", vif.req_a, 1'b0);
    chk("rst_req_b", vif.req_b, 1'b0);
    chk("rst_wb_en_a", vif.wb_en_a, 1'b0);
    chk("rst_wb_en_b", vif.wb_en_b, 1'b0);
    chk("rst_addr_a", vif.addr_a, 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_inputs();
    vif.valid = 0; vif.op = '0; vif.ready_in = 0; vif.vec_res = 0;
    vif.imm_a = '0; vif.imm_b = '0; vif.rs1_a = '0; vif.rs1_b = '0;
    vif.vd_a = '0; vif.vd_b = '0; vif.v2_a = '0; vif.v2_b = '0;
    vif.row_col_a = 0; vif.row_col_b = 0; vif.num_rows_a = '0; vif.num_rows_b = '0;
    vif.num_cols_a = '0; vif.num_cols_b = '0; vif.id_a = 0; vif.id_b = 0;
    vif.load_data_a = '0; vif.load_data_b = '0;
  endtask

  task automatic rand_inputs();
    int r;
    r = $urandom_range(0, 9);
    vif.op       = (r < 4) ? LD : (r < 8) ? ST : 7'($urandom);
    vif.valid    = ($urandom_range(0, 3) != 0);
    vif.ready_in = ($urandom_range(0, 3) != 0);
    vif.vec_res  = ($urandom_range(0, 2) == 0);
    vif.imm_a = $urandom; vif.imm_b = $urandom; vif.rs1_a = $urandom; vif.rs1_b = $urandom;
    vif.vd_a = 4'($urandom); vif.vd_b = 4'($urandom);
    vif.v2_a = 4'($urandom); vif.v2_b = 4'($urandom);
    vif.row_col_a = 1'($urandom); vif.row_col_b = 1'($urandom);
    vif.num_rows_a = 5'($urandom); vif.num_rows_b = 5'($urandom);
    vif.num_cols_a = 5'($urandom); vif.num_cols_b = 5'($urandom);
    vif.id_a = 1'($urandom); vif.id_b = 1'($urandom);
    vif.load_data_a = {$urandom, $urandom, $urandom, $urandom};
    vif.load_data_b = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    model_clear();
    repeat (5) @(posedge clk);
    #1;
    chk("idle_req_a", vif.req_a, 1'b0);
    chk("idle_req_b", vif.req_b, 1'b0);
    chk("idle_wb_en_a", vif.wb_en_a, 1'b0);
    chk("idle_wb_en_b", vif.wb_en_b, 1'b0);
    chk("idle_ready_out", vif.ready_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // store opcode with memory not ready, response on empty queues
    vif.valid = 1; vif.op = ST; vif.ready_in = 0; vif.vec_res = 1;
    tick();
    chk("noready_req_a", vif.req_a, 1'b0);
    chk("empty_wb_en_b", vif.wb_en_b, 1'b0);

    // store issue
    vif.vec_res = 0; vif.ready_in = 1;
    vif.rs1_a = 50; vif.rs1_b = 50; vif.imm_a = 10; vif.imm_b = 15;
    vif.v2_a = 1; vif.v2_b = 1;
    tick();
    chk("st_req_a", vif.req_a, 1'b1);
    chk("st_wen_b", vif.wen_b, 1'b1);
    chk("st_addr_a", vif.addr_a, 32'd60);
    chk("st_addr_b", vif.addr_b, 32'd65);
    chk("st_vs_a", vif.vs_a, 4'd1);

    // loads until both queues are full, then stall
    vif.op = LD; vif.vd_a = 1; vif.vd_b = 2;
    tick();
    chk("ld_wen_a", vif.wen_a, 1'b0);
    chk("ld_addr_b", vif.addr_b, 32'd65);
    repeat (3) tick();
    chk("full_ready_out", vif.ready_out, 1'b0);
    tick();
    chk("stall_req_a", vif.req_a, 1'b0);

    // drain
    vif.valid = 0; vif.vec_res = 1;
    vif.load_data_a = {4{32'd10}}; vif.load_data_b = {4{32'd10}};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_wb_en_a", vif.wb_en_a, 1'b1);
      chk("drain_wb_vd_b", vif.wb_vd_b, 4'd2);
      chk("drain_wb_data_a", vif.wb_data_a, {4{32'd10}});
    end
    tick();
    chk("drained_wb_en_a", vif.wb_en_a, 1'b0);

    // issue resumes, leave two loads pending, then reset drops them
    vif.vec_res = 0; vif.valid = 1;
    tick();
    chk("resume_req_b", vif.req_b, 1'b1);
    tick();
    do_reset();
    vif.valid = 0; vif.vec_res = 1;
    tick();
    chk("post_rst_wb_en_a", vif.wb_en_a, 1'b0);
    chk("post_rst_wb_en_b", vif.wb_en_b, 1'b0);

    for (int n = 0; n < 600; n++) begin
      rand_inputs();
      if ($urandom_range(0, 149) == 0) do_reset();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
